syncro_filt: RTL and testbench
==============================

SYNCRO_FILT -- requirements
Module: syncro_filt

Interface
REQ-001 Parameter WIDTH, default 8: number of independent single-bit channels, legal range 1..64.
REQ-002 Parameter STAGES, default 2: synchronizer flop depth per channel, legal range 2..4.
REQ-003 Parameter FILT_CNT, default 4: consecutive stable clocks required before an output changes, legal range 1..255.
REQ-004 Parameter RST_VAL, default 0 (WIDTH bits): reset value of sig_out and of every synchronizer flop.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  reset, synchronous, active-low.
REQ-007 sig_in  in  WIDTH  asynchronous inputs, one per channel.
REQ-008 sig_out  out  WIDTH  synchronized, debounced level per channel, registered.
REQ-009 rise  out  WIDTH  one-clock pulse per channel on a sig_out 0->1 transition, registered.
REQ-010 fall  out  WIDTH  one-clock pulse per channel on a sig_out 1->0 transition, registered.
REQ-011 chg  out  1  OR of rise|fall, registered, coincident with those pulses.

Function
REQ-012 Each channel SHALL pass sig_in through a STAGES-deep flop chain; the last flop is the synchronized value s.
REQ-013 Each channel SHALL hold a counter cnt of width clog2(FILT_CNT+1).
REQ-014 When s == sig_out, cnt SHALL be cleared to 0.
REQ-015 When s != sig_out and cnt < FILT_CNT-1, cnt SHALL increment by 1.
REQ-016 When s != sig_out and cnt == FILT_CNT-1, sig_out SHALL load s on that edge and cnt SHALL clear to 0.
REQ-017 cnt SHALL never exceed FILT_CNT-1 and SHALL never wrap.
REQ-018 A reversion of s before the count completes SHALL clear cnt; a pulse shorter than FILT_CNT synchronized clocks SHALL never reach sig_out.
REQ-019 Latency: sig_out SHALL change on the (STAGES+FILT_CNT)th rising edge, counting the first edge that captures the new sig_in level as edge 1.
REQ-020 rise[i]/fall[i] SHALL be high for exactly the first cycle sig_out[i] holds its new value.
REQ-021 Channels SHALL be fully independent; simultaneous events on several channels SHALL assert their pulse bits in the same cycle.

Reset
REQ-022 While reset_n is low at a clk edge: sync flops and sig_out = RST_VAL, cnt = 0, rise = fall = 0, chg = 0.
REQ-023 Reset asserted mid-count SHALL discard the count; no pulse SHALL be emitted during or on the cycle of reset release.
REQ-024 After release, an input differing from RST_VAL SHALL reach sig_out per REQ-019 and SHALL generate the matching pulse.

Configuration
REQ-025 Macro SYNCRO_FILT_EDGE_EN defined: rise, fall and chg are implemented as specified.
REQ-026 Macro SYNCRO_FILT_EDGE_EN undefined: rise, fall and chg are tied to 0, edge registers are absent, and sig_out behaviour is unchanged.

Structure
REQ-027 Package syncro_pkg SHALL hold the parameter-range constants (min/max STAGES, max FILT_CNT) and the counter-width function.
REQ-028 The per-channel chain, counter and edge logic SHALL be the sub-module syncro_filt_chan, instantiated WIDTH times via generate.
REQ-029 Out-of-range parameters SHALL cause an elaboration-time error.
REQ-030 Synchronizer flops SHALL carry the ASYNC_REG attribute.

Verification (WIDTH=4, STAGES=2, FILT_CNT=4, RST_VAL=0, SYNCRO_FILT_EDGE_EN defined unless stated)
REQ-031 Hold sig_in=4'hF with reset_n low for 3 clocks, then release -> sig_out=0 and rise=0 throughout reset; sig_out=4'hF on the 6th edge after release; rise=4'hF and chg=1 for that one cycle.
REQ-032 Raise sig_in[0] for 3 clocks, then drop it -> sig_out[0] stays 0; rise stays 0.
REQ-033 Raise sig_in[0] and hold it -> sig_out[0]=1 on edge 6 with rise=4'b0001 for one cycle; drop it later -> fall=4'b0001 six edges after the drop.
REQ-034 With sig_out=4'b0100, drive sig_in=4'b0010 on a single edge -> rise=4'b0010 and fall=4'b0100 in the same cycle; chg=1 for that one cycle.
REQ-035 Assert reset_n low at cnt=2 of a pending rise on channel 3 -> no rise pulse; after release, sig_out[3]=1 six edges later.
REQ-036 Rebuild with SYNCRO_FILT_EDGE_EN undefined and rerun REQ-033 -> identical sig_out; rise, fall and chg are constant 0.

Source files
------------

// File: rtl/syncro_pkg.sv
// ----------------------------------------------------------------------------
// syncro_pkg : parameter limits and counter sizing for the syncro_filt family.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package syncro_pkg;

   localparam int c_width_min    = 1;
   localparam int c_width_max    = 64;
   localparam int c_stages_min   = 2;
   localparam int c_stages_max   = 4;
   localparam int c_filt_cnt_min = 1;
   localparam int c_filt_cnt_max = 255;

   function automatic int cnt_width(input int filt_cnt);
      return $clog2(filt_cnt + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/syncro_filt_chan.sv
// ----------------------------------------------------------------------------
// syncro_filt_chan : one channel of synchronizer, stability filter and edge
// pulse generation (edge pulses only with SYNCRO_FILT_EDGE_EN). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module syncro_filt_chan
   import syncro_pkg::*;
#(
   parameter int   STAGES   = 2,
   parameter int   FILT_CNT = 4,
   parameter logic RST_BIT  = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_sig,
   output logic o_sig,
`ifdef SYNCRO_FILT_EDGE_EN
   output logic o_chg_d,
`endif
   output logic o_rise,
   output logic o_fall
);

   localparam int               CNT_W      = cnt_width(FILT_CNT);
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(FILT_CNT - 1);

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              out_q, out_d;
   logic              w_s;

   // The filter only advances while the synchronized level disagrees with the output.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], i_sig};
      w_s    = sync_q[STAGES-1];
      out_d  = out_q;
      cnt_d  = '0;
      if (w_s != out_q) begin
         if (cnt_q == c_cnt_last) begin
            out_d = w_s;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q <= {STAGES{RST_BIT}};
         cnt_q  <= '0;
         out_q  <= RST_BIT;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         out_q  <= out_d;
      end
   end

   assign o_sig = out_q;

`ifdef SYNCRO_FILT_EDGE_EN
   logic rise_q, rise_d;
   logic fall_q, fall_d;

   always_comb begin
      rise_d  = out_d & ~out_q;
      fall_d  = ~out_d & out_q;
      o_chg_d = rise_d | fall_d;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign o_rise = rise_q;
   assign o_fall = fall_q;
`else
   assign o_rise = 1'b0;
   assign o_fall = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/syncro_filt.sv
// ----------------------------------------------------------------------------
// syncro_filt : WIDTH-channel synchronizer with debounce filter; edge pulses
// and chg are built only when SYNCRO_FILT_EDGE_EN is defined. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module syncro_filt
   import syncro_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter int               STAGES   = 2,
   parameter int               FILT_CNT = 4,
   parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sig_in,
   output logic [WIDTH-1:0] sig_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             chg
);

   if (WIDTH < c_width_min || WIDTH > c_width_max) begin : g_bad_width
      $error("syncro_filt: WIDTH %0d out of range", WIDTH);
   end
   if (STAGES < c_stages_min || STAGES > c_stages_max) begin : g_bad_stages
      $error("syncro_filt: STAGES %0d out of range", STAGES);
   end
   if (FILT_CNT < c_filt_cnt_min || FILT_CNT > c_filt_cnt_max) begin : g_bad_filt
      $error("syncro_filt: FILT_CNT %0d out of range", FILT_CNT);
   end

`ifdef SYNCRO_FILT_EDGE_EN
   logic [WIDTH-1:0] w_chg_d;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      syncro_filt_chan #(
         .STAGES   (STAGES),
         .FILT_CNT (FILT_CNT),
         .RST_BIT  (RST_VAL[i])
      ) u_chan (
         .clk     (clk),
         .reset_n (reset_n),
         .i_sig   (sig_in[i]),
         .o_sig   (sig_out[i]),
`ifdef SYNCRO_FILT_EDGE_EN
         .o_chg_d (w_chg_d[i]),
`endif
         .o_rise  (rise[i]),
         .o_fall  (fall[i])
      );
   end

`ifdef SYNCRO_FILT_EDGE_EN
   logic chg_q, chg_d;

   // Registered from next-state pulses so chg lines up with rise/fall.
   always_comb begin
      chg_d = |w_chg_d;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         chg_q <= 1'b0;
      end else begin
         chg_q <= chg_d;
      end
   end

   assign chg = chg_q;
`else
   assign chg = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_syncro_filt.sv
// ----------------------------------------------------------------------------
// tb_syncro_filt : directed and random checks of syncro_filt against a
// run-length reference model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_syncro_filt;

   localparam int         WIDTH    = 4;
   localparam int         STAGES   = 2;
   localparam int         FILT_CNT = 4;
   localparam logic [3:0] RST_VAL  = 4'h0;
`ifdef SYNCRO_FILT_EDGE_EN
   localparam bit         EDGE_EN  = 1'b1;
`else
   localparam bit         EDGE_EN  = 1'b0;
`endif

   logic             clk;
   logic             reset_n;
   logic [WIDTH-1:0] sig_in;
   logic [WIDTH-1:0] sig_out;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic             chg;

   int n_total = 0;
   int n_bad   = 0;
   bit chk_en  = 1'b0;

   syncro_filt #(
      .WIDTH    (WIDTH),
      .STAGES   (STAGES),
      .FILT_CNT (FILT_CNT),
      .RST_VAL  (RST_VAL)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .sig_in  (sig_in),
      .sig_out (sig_out),
      .rise    (rise),
      .fall    (fall),
      .chg     (chg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a level only moves to the output after the synchronized
   // value has disagreed with it for FILT_CNT edges in a row.
   logic [WIDTH-1:0] m_hist [STAGES];
   logic [WIDTH-1:0] m_out, m_rise, m_fall;
   logic             m_chg;
   int               m_run [WIDTH];

   always @(posedge clk) begin
      logic [WIDTH-1:0] s, nxt;
      if (!reset_n) begin
         for (int k = 0; k < STAGES; k++) m_hist[k] = RST_VAL;
         for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
         m_out  = RST_VAL;
         m_rise = '0;
         m_fall = '0;
         m_chg  = 1'b0;
      end else begin
         s   = m_hist[STAGES-1];
         nxt = m_out;
         for (int i = 0; i < WIDTH; i++) begin
            if (s[i] != m_out[i]) begin
               m_run[i] = m_run[i] + 1;
               if (m_run[i] >= FILT_CNT) begin
                  nxt[i]   = s[i];
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         m_rise = EDGE_EN ? (nxt & ~m_out) : '0;
         m_fall = EDGE_EN ? (~nxt & m_out) : '0;
         m_chg  = |(m_rise | m_fall);
         m_out  = nxt;
         for (int k = STAGES - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = sig_in;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check_val("m_sig_out", 32'(sig_out), 32'(m_out));
         check_val("m_rise",    32'(rise),    32'(m_rise));
         check_val("m_fall",    32'(fall),    32'(m_fall));
         check_val("m_chg",     32'(chg),     32'(m_chg));
      end
   end

   initial begin
      reset_n = 1'b0;
      sig_in  = 4'hF;
      @(posedge clk);
      chk_en = 1'b1;

      // Input held high through reset, then released
      repeat (3) @(negedge clk);
      check_val("rst_out",  32'(sig_out), 32'h0);
      check_val("rst_rise", 32'(rise),    32'h0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check_val("rel_e5_out", 32'(sig_out), 32'h0);
      @(negedge clk);
      check_val("rel_e6_out",  32'(sig_out), 32'hF);
      check_val("rel_e6_rise", 32'(rise),    EDGE_EN ? 32'hF : 32'h0);
      check_val("rel_e6_chg",  32'(chg),     EDGE_EN ? 32'h1 : 32'h0);
      @(negedge clk);
      check_val("rel_e7_rise", 32'(rise), 32'h0);
      sig_in = 4'h0;
      repeat (8) @(negedge clk);

      // Three-clock glitch must be filtered out
      sig_in = 4'b0001;
      repeat (3) @(negedge clk);
      sig_in = 4'b0000;
      repeat (8) @(negedge clk);
      check_val("glitch_out", 32'(sig_out), 32'h0);

      // Held rise, then fall
      sig_in = 4'b0001;
      repeat (5) @(negedge clk);
      check_val("hold_e5_out", 32'(sig_out), 32'h0);
      @(negedge clk);
      check_val("hold_e6_out",  32'(sig_out), 32'h1);
      check_val("hold_e6_rise", 32'(rise),    EDGE_EN ? 32'h1 : 32'h0);
      repeat (4) @(negedge clk);
      sig_in = 4'b0000;
      repeat (5) @(negedge clk);
      check_val("drop_e5_out", 32'(sig_out), 32'h1);
      @(negedge clk);
      check_val("drop_e6_out",  32'(sig_out), 32'h0);
      check_val("drop_e6_fall", 32'(fall),    EDGE_EN ? 32'h1 : 32'h0);

      // Simultaneous rise on one channel and fall on another
      sig_in = 4'b0100;
      repeat (8) @(negedge clk);
      check_val("pre_swap_out", 32'(sig_out), 32'h4);
      sig_in = 4'b0010;
      repeat (6) @(negedge clk);
      check_val("swap_out",  32'(sig_out), 32'h2);
      check_val("swap_rise", 32'(rise),    EDGE_EN ? 32'h2 : 32'h0);
      check_val("swap_fall", 32'(fall),    EDGE_EN ? 32'h4 : 32'h0);
      check_val("swap_chg",  32'(chg),     EDGE_EN ? 32'h1 : 32'h0);
      @(negedge clk);
      check_val("swap_chg_end", 32'(chg), 32'h0);
      sig_in = 4'b0000;
      repeat (8) @(negedge clk);

      // Reset mid-count on channel 3
      sig_in = 4'b1000;
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check_val("midrst_out",  32'(sig_out), 32'h0);
      check_val("midrst_rise", 32'(rise),    32'h0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      check_val("midrst_e5_out", 32'(sig_out), 32'h0);
      @(negedge clk);
      check_val("midrst_e6_out",  32'(sig_out), 32'h8);
      check_val("midrst_e6_rise", 32'(rise),    EDGE_EN ? 32'h8 : 32'h0);

      // Random toggling with occasional resets
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         for (int i = 0; i < WIDTH; i++) begin
            if ($urandom_range(5) == 0) sig_in[i] = ~sig_in[i];
         end
         reset_n = ($urandom_range(199) != 0);
      end
      reset_n = 1'b1;
      repeat (10) @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
